sync_bcd_counter: RTL and testbench

SYNC_BCD_COUNTER -- requirements
Module: sync_bcd_counter

---
 rtl/sync_bcd_counter_pkg.sv | 18 +
 rtl/bcd_digit.sv | 60 ++++++
 rtl/sync_bcd_counter.sv | 95 +++++++++
 tb/tb_sync_bcd_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sync_bcd_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_bcd_counter_pkg
// Description : Shared constants for the synchronous BCD counter slice:
//               digit width and up/down mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_bcd_counter_pkg;

    // Every digit is carried in a nibble, whatever the radix
    localparam int   c_DIGIT_W   = 4;

    // up_down encoding
    localparam logic c_MODE_UP   = 1'b1;
    localparam logic c_MODE_DOWN = 1'b0;

endpackage : sync_bcd_counter_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One modulo-RADIX counter digit with synchronous clear and
//               parallel load. Priority: clear > load > step.
// Ports       : clock       - rising-edge clock
//               clear       - synchronous active-high reset
//               step        - advance one position this edge
//               up_down     - 1 = increment, 0 = decrement
//               load        - parallel-load strobe
//               load_nibble - load data (out-of-range values load as 0)
//               digit       - registered digit value
//               at_max      - digit == RADIX-1
//               at_min      - digit == 0
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import sync_bcd_counter_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 step,
    input  logic                 up_down,
    input  logic                 load,
    input  logic [c_DIGIT_W-1:0] load_nibble,
    output logic [c_DIGIT_W-1:0] digit,
    output logic                 at_max,
    output logic                 at_min
);

    // One extra bit so RADIX=16 is representable in the range compare
    localparam logic [c_DIGIT_W:0]   c_RADIX = (c_DIGIT_W + 1)'(RADIX);
    localparam logic [c_DIGIT_W-1:0] c_MAX   = c_DIGIT_W'(RADIX - 1);

    logic [c_DIGIT_W-1:0] r_digit;
    logic                 w_load_ok;

    assign w_load_ok = ({1'b0, load_nibble} < c_RADIX);
    assign at_max    = (r_digit == c_MAX);
    assign at_min    = (r_digit == '0);
    assign digit     = r_digit;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= w_load_ok ? load_nibble : '0;
        end else if (step) begin
            if (up_down == c_MODE_UP) begin
                r_digit <= at_max ? '0 : r_digit + c_DIGIT_W'(1);
            end else begin
                r_digit <= at_min ? c_MAX : r_digit - c_DIGIT_W'(1);
            end
        end
    end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/sync_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_bcd_counter
// Description : Fully synchronous cascaded up/down counter of DIGITS digits,
//               each modulo RADIX, with parallel load and range checking.
// Ports       : clock      - rising-edge clock
//               clear      - synchronous active-high reset
//               enable     - count-enable qualifier
//               up_down    - 1 = count up, 0 = count down
//               load       - parallel-load strobe (overrides enable)
//               load_value - load data, digit 0 in [3:0]
//               count      - registered counter value, digit 0 in [3:0]
//               tc         - combinational terminal count
//               wrap       - one-cycle pulse after a wrapping count step
//               load_err   - one-cycle pulse after a load with a bad nibble
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bcd_counter
    import sync_bcd_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          up_down,
    input  logic                          load,
    input  logic [c_DIGIT_W*DIGITS-1:0]   load_value,
    output logic [c_DIGIT_W*DIGITS-1:0]   count,
    output logic                          tc,
    output logic                          wrap,
    output logic                          load_err
);

    localparam logic [c_DIGIT_W:0] c_RADIX = (c_DIGIT_W + 1)'(RADIX);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_step;
    logic [DIGITS-1:0] w_nib_bad;
    // Entry k is high when every digit below k sits at its limit
    logic [DIGITS:0]   w_max_chain;
    logic [DIGITS:0]   w_min_chain;
    logic              r_wrap;
    logic              r_load_err;

    assign w_max_chain[0] = 1'b1;
    assign w_min_chain[0] = 1'b1;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_max_chain[k+1] = w_max_chain[k] & w_at_max[k];
            assign w_min_chain[k+1] = w_min_chain[k] & w_at_min[k];
            assign w_step[k]        = enable &
                ((up_down == c_MODE_UP) ? w_max_chain[k] : w_min_chain[k]);
            assign w_nib_bad[k]     =
                ({1'b0, load_value[k*c_DIGIT_W +: c_DIGIT_W]} >= c_RADIX);

            bcd_digit #(
                .RADIX       (RADIX)
            ) u_digit (
                .clock       (clock),
                .clear       (clear),
                .step        (w_step[k]),
                .up_down     (up_down),
                .load        (load),
                .load_nibble (load_value[k*c_DIGIT_W +: c_DIGIT_W]),
                .digit       (count[k*c_DIGIT_W +: c_DIGIT_W]),
                .at_max      (w_at_max[k]),
                .at_min      (w_at_min[k])
            );
        end
    endgenerate

    // Full chain high means the next enabled step rolls every digit over
    assign tc = enable &
        ((up_down == c_MODE_UP) ? w_max_chain[DIGITS] : w_min_chain[DIGITS]);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            // A load in the same cycle suppresses the count step and its wrap
            r_wrap     <= tc & ~load;
            r_load_err <= load & (|w_nib_bad);
        end
    end

    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule : sync_bcd_counter
`default_nettype wire

// File: tb/tb_sync_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_bcd_counter
// Description : Self-checking bench. Two counters (RADIX 10 and RADIX 16,
//               4 digits each) share one stimulus stream; a numeric model
//               predicts each cycle's result into a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_bcd_counter;

    typedef struct packed {
        logic [15:0] cnt;
        logic        wrap;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        up_down = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;

    logic [15:0] cnt_o  [2];
    logic        tc_o   [2];
    logic        wrap_o [2];
    logic        err_o  [2];

    exp_t sb[$];
    int   m_val [2];
    int   rad   [2] = '{10, 16};
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    sync_bcd_counter #(.DIGITS(4), .RADIX(10)) u_dut10 (
        .clock      (clk),
        .clear      (clear),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (cnt_o[0]),
        .tc         (tc_o[0]),
        .wrap       (wrap_o[0]),
        .load_err   (err_o[0])
    );

    sync_bcd_counter #(.DIGITS(4), .RADIX(16)) u_dut16 (
        .clock      (clk),
        .clear      (clear),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (cnt_o[1]),
        .tc         (tc_o[1]),
        .wrap       (wrap_o[1]),
        .load_err   (err_o[1])
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_digits(input int v, input int r);
        logic [15:0] d;
        int          x;
        x = v;
        for (int k = 0; k < 4; k++) begin
            d[k*4 +: 4] = 4'(x % r);
            x           = x / r;
        end
        return d;
    endfunction

    // One cycle: apply inputs, check tc, predict, clock, compare registered outputs
    task automatic step(input logic clr, input logic en, input logic ud,
                        input logic ld, input logic [15:0] lv);
        exp_t e;
        int   modv;
        int   nv;
        int   nib;
        logic exp_tc;
        logic bad;
        @(negedge clk);
        clear = clr; enable = en; up_down = ud; load = ld; load_value = lv;
        #1;
        for (int i = 0; i < 2; i++) begin
            modv   = rad[i] * rad[i] * rad[i] * rad[i];
            exp_tc = en && (ud ? (m_val[i] == modv - 1) : (m_val[i] == 0));
            check_value($sformatf("tc%0d", rad[i]), 32'(tc_o[i]), 32'(exp_tc));
            e.wrap = 1'b0;
            e.err  = 1'b0;
            if (clr) begin
                m_val[i] = 0;
            end else if (ld) begin
                nv  = 0;
                bad = 1'b0;
                for (int k = 3; k >= 0; k--) begin
                    nib = int'(lv[k*4 +: 4]);
                    if (nib >= rad[i]) begin
                        bad = 1'b1;
                        nib = 0;
                    end
                    nv = nv * rad[i] + nib;
                end
                m_val[i] = nv;
                e.err    = bad;
            end else if (en) begin
                e.wrap   = exp_tc;
                m_val[i] = ud ? (m_val[i] + 1) % modv : (m_val[i] + modv - 1) % modv;
            end
            e.cnt = to_digits(m_val[i], rad[i]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (sb.size() == 0) begin
                check_value("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_value($sformatf("count%0d", rad[i]), 32'(cnt_o[i]), 32'(e.cnt));
                check_value($sformatf("wrap%0d", rad[i]), 32'(wrap_o[i]), 32'(e.wrap));
                check_value($sformatf("load_err%0d", rad[i]), 32'(err_o[i]), 32'(e.err));
            end
        end
    endtask

    initial begin
        m_val[0] = 0;
        m_val[1] = 0;

        // Reset, then reset held with a down-enable (tc high at zero)
        step(1, 0, 1, 0, 16'h0000);
        step(1, 1, 0, 1, 16'h1234);

        // Full up-count sweep through terminal count and wrap
        for (int n = 0; n < 10000; n++) step(0, 1, 1, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0000);

        // Down from zero wraps to all-max
        step(0, 0, 1, 1, 16'h0000);
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 16'h0000);

        // Load range checking
        step(0, 0, 1, 1, 16'h12A9);
        step(0, 0, 1, 1, 16'h0919);

        // Load beats enable, then counting continues from loaded value
        step(0, 0, 1, 1, 16'h0199);
        step(0, 1, 1, 1, 16'h0500);
        step(0, 1, 1, 0, 16'h0000);

        // Clear beats load and enable mid-count, counting resumes from 0
        step(0, 0, 1, 1, 16'h4567);
        step(0, 1, 1, 0, 16'h0000);
        step(1, 1, 1, 1, 16'h0999);
        step(0, 1, 1, 0, 16'h0000);

        // Direction change with no lost or extra step
        step(0, 0, 1, 1, 16'h0009);
        step(0, 1, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 16'h0000);

        // Top-of-range for RADIX 16 (invalid for RADIX 10)
        step(0, 0, 1, 1, 16'hFFFE);
        step(0, 1, 1, 0, 16'h0000);
        step(0, 1, 1, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0000);

        // Random mixed traffic near the edges
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
                 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_sync_bcd_counter
`default_nettype wire
